mem_stage_sb: RTL and testbench
===============================

MEM_STAGE_SB -- requirements
Module: mem_stage_sb

Interface
REQ-001 SHALL have parameter DW, default 16: data width.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter SB_DEPTH, default 4: store-buffer entries; power of 2, at least 2.
REQ-004 SHALL use one clock and a synchronous active-high reset, with ports named clk and rst.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- MemRead  in  1  load request
- MemWrite  in  1  store request
- createdump  in  1  request a memory dump
- WriteDataPC  in  1  writeback source select: PC
- WriteDataMem  in  1  writeback source select: load data
- ALUData  in  AW  effective address
- wdata  in  DW  store data
- PCData  in  DW  PC value for writeback
- out  out  DW  writeback value
- MemStall  out  1  holds the pipeline
- MemErr  out  1  sticky error
- m_addr  out  AW  memory address
- m_din  out  DW  memory write data
- m_rd  out  1  memory read pulse
- m_wr  out  1  memory write pulse
- m_createdump  out  1  dump pulse to memory
- m_dout  in  DW  memory read data
- m_stall  in  1  memory busy; no request accepted this cycle
- m_done  in  1  memory completion pulse
- m_err  in  1  memory error

Function
REQ-006 SHALL drive out as: PCData if WriteDataPC; else load data if WriteDataMem; else ALUData.
REQ-007 SHALL keep an in-order FIFO of SB_DEPTH {addr, data} entries:
- occupancy range is 0..SB_DEPTH;
- head and tail pointers wrap modulo SB_DEPTH.
REQ-008 SHALL handle a store (MemWrite) as follows:
- not full: enqueue in the same cycle with MemStall=0;
- full: MemStall=1 until a slot frees.
REQ-009 SHALL treat a store m_done as freeing a slot in the same cycle, so a store arriving while full enqueues that cycle without stalling.
REQ-010 SHALL forward a load whose ALUData matches any buffer entry:
- data comes from the youngest matching entry;
- forwarded data appears on the same cycle with MemStall=0;
- no memory access is made.
REQ-011 SHALL implement drain FSM states IDLE, WR_WAIT, RD_WAIT, DUMP, ERR.
REQ-012 SHALL behave in IDLE, checking in this priority order, with each request pulsed only when m_stall=0:
1. load miss: pulse m_rd with m_addr=ALUData and go to RD_WAIT;
2. buffer non-empty: pulse m_wr with the head entry and go to WR_WAIT;
3. createdump with the buffer empty: pulse m_createdump and go to DUMP.
REQ-013 SHALL hold MemStall=1 during a load miss from the request cycle until m_done. In the m_done cycle:
- out reflects m_dout combinationally;
- MemStall=0;
- next state is IDLE;
- no re-issue occurs even though MemRead is still high.
REQ-014 SHALL handle WR_WAIT: on m_done, dequeue the head and go to IDLE; the head entry stays searchable for forwarding until that dequeue.
REQ-015 SHALL keep MemStall=1 from a createdump until the buffer is drained and the DUMP m_done has arrived.
REQ-016 SHALL treat MemRead and MemWrite asserted together as illegal:
- neither operation is performed;
- MemErr is set.
REQ-017 SHALL respond to m_err in any state by setting MemErr, entering ERR, and then:
- issuing no further requests;
- holding MemStall=1 until rst.
REQ-018 SHALL keep m_rd, m_wr and m_createdump each high for at most one cycle per request, and never more than one of them high in the same cycle.

Reset
REQ-019 SHALL on rst: empty the buffer, zero both pointers and the count, enter IDLE, and clear MemErr.
REQ-020 SHALL abandon any in-flight request on rst and ignore a late m_done that follows it.
REQ-021 SHALL hold all m_* request outputs and MemStall at 0 during rst.

Structure
REQ-022 SHALL place the FSM state enum and the DW/AW defaults in the shared package mem_stage_pkg.
REQ-023 SHALL implement the FIFO plus youngest-match address search as sub-module store_buffer.

Verification
REQ-024 SHALL cover store then forward:
- stimulus: store 0x0040<-0xBEEF, then the next cycle load 0x0040 with m_stall=1;
- required: out=0xBEEF, MemStall=0, m_rd never pulses.
REQ-025 SHALL cover full buffer:
- stimulus: SB_DEPTH+1 back-to-back stores with m_stall held high;
- required: MemStall=1 on the 5th store only; it enqueues in the cycle the first m_done arrives.
REQ-026 SHALL cover load miss:
- stimulus: load 0x0100 with an empty buffer, m_done 3 cycles later with m_dout=0x1234;
- required: MemStall=1 for 3 cycles, then out=0x1234, then exactly one m_rd observed.
REQ-027 SHALL cover drain ordering:
- stimulus: stores to A, B, A (data 1, 2, 3);
- required: m_wr order is A/1, B/2, A/3; a load of A before the drain returns 3.
REQ-028 SHALL cover createdump:
- stimulus: createdump with 2 entries buffered;
- required: two m_wr, then one m_createdump; MemStall is released only after the dump's m_done.
REQ-029 SHALL cover error and reset:
- stimulus: m_err during WR_WAIT, then rst;
- required: MemErr=1 and no requests until rst; after rst, count=0, state IDLE, MemErr=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage and its store buffer.
package mem_stage_pkg;
  localparam int DW_DEF       = 16;
  localparam int AW_DEF       = 16;
  localparam int SB_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    DUMP,
    ERR
  } state_t;
endpackage

// File: rtl/store_buffer.sv
// In-order {addr,data} FIFO with a youngest-match address search; enqueue and search are
// same-cycle, and an enqueue while full is accepted only alongside a dequeue.
module store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enq,
  input  logic [AW-1:0] i_enq_addr,
  input  logic [DW-1:0] i_enq_data,
  input  logic          i_deq,
  input  logic [AW-1:0] i_srch_addr,
  output logic          o_hit,
  output logic [DW-1:0] o_hit_data,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_enq;
  logic          w_do_deq;
  logic [PW-1:0] w_idx;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign w_do_deq    = i_deq & ~o_empty;
  assign w_do_enq    = i_enq & (~o_full | w_do_deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) r_tail <= r_tail + PTR_ONE;
      if (w_do_deq) r_head <= r_head + PTR_ONE;
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) begin
      r_addr[r_tail] <= i_enq_addr;
      r_data[r_tail] <= i_enq_data;
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_idx] == i_srch_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_idx];
      end
    end
  end
endmodule

// File: rtl/mem_stage_sb.sv
// Pipeline memory stage with a forwarding store buffer drained to memory one request at a time;
// stores and forwarded loads complete same-cycle, misses/full buffer/dump/error raise MemStall.
module mem_stage_sb
  import mem_stage_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          createdump,
  input  logic          WriteDataPC,
  input  logic          WriteDataMem,
  input  logic [AW-1:0] ALUData,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] PCData,
  output logic [DW-1:0] out,
  output logic          MemStall,
  output logic          MemErr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic          m_rd,
  output logic          m_wr,
  output logic          m_createdump,
  input  logic [DW-1:0] m_dout,
  input  logic          m_stall,
  input  logic          m_done,
  input  logic          m_err
);
  state_t        r_state;
  state_t        w_next;
  logic          r_mem_err;
  logic          r_dump_pend;

  logic          w_ld;
  logic          w_st;
  logic          w_illegal;
  logic          w_dump_req;
  logic          w_hit;
  logic [DW-1:0] w_hit_data;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_deq;
  logic          w_ld_stall;
  logic          w_st_stall;
  logic          w_dump_stall;
  logic          w_stall;
  logic [DW-1:0] w_ld_data;

  assign w_ld       = MemRead & ~MemWrite;
  assign w_st       = MemWrite & ~MemRead;
  assign w_illegal  = MemRead & MemWrite;
  assign w_dump_req = createdump | r_dump_pend;
  assign MemErr     = r_mem_err;

  store_buffer #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_enq       (w_enq),
    .i_enq_addr  (ALUData),
    .i_enq_data  (wdata),
    .i_deq       (w_deq),
    .i_srch_addr (ALUData),
    .o_hit       (w_hit),
    .o_hit_data  (w_hit_data),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A store completing this cycle frees its slot for a store arriving on a full buffer.
  always_comb begin
    w_deq        = (r_state == WR_WAIT) & m_done & ~rst;
    w_ld_stall   = w_ld & ((r_state == RD_WAIT) ? ~m_done : ~w_hit);
    w_st_stall   = w_st & w_full & ~w_deq;
    w_dump_stall = w_dump_req & ~((r_state == DUMP) & m_done);
    w_stall      = (r_state == ERR) | m_err | w_ld_stall | w_st_stall | w_dump_stall;
    MemStall     = ~rst & w_stall;
    w_enq        = w_st & ~w_stall & ~rst;
    w_ld_data    = ((r_state != RD_WAIT) && w_hit) ? w_hit_data : m_dout;
    if (WriteDataPC)       out = PCData;
    else if (WriteDataMem) out = w_ld_data;
    else                   out = DW'(ALUData);
  end

  always_comb begin
    w_next       = r_state;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    m_createdump = 1'b0;
    m_addr       = '0;
    m_din        = '0;
    if (m_err) begin
      w_next = ERR;
    end else begin
      case (r_state)
        IDLE: begin
          if (!m_stall) begin
            if (w_ld && !w_hit) begin
              m_rd   = 1'b1;
              m_addr = ALUData;
              w_next = RD_WAIT;
            end else if (!w_empty) begin
              m_wr   = 1'b1;
              m_addr = w_head_addr;
              m_din  = w_head_data;
              w_next = WR_WAIT;
            end else if (w_dump_req) begin
              m_createdump = 1'b1;
              w_next       = DUMP;
            end
          end
        end
        WR_WAIT, RD_WAIT, DUMP: if (m_done) w_next = IDLE;
        ERR:     w_next = ERR;
        default: w_next = IDLE;
      endcase
    end
    if (rst) begin
      w_next       = IDLE;
      m_rd         = 1'b0;
      m_wr         = 1'b0;
      m_createdump = 1'b0;
      m_addr       = '0;
      m_din        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_err   <= 1'b0;
      r_dump_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (m_err || w_illegal) r_mem_err <= 1'b1;
      if ((r_state == DUMP) && m_done)          r_dump_pend <= 1'b0;
      else if (createdump && (r_state != ERR))  r_dump_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Scenario bench for mem_stage_sb: expected drain writes are queued as stores are driven.
module tb_mem_stage_sb;
  import mem_stage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          MemRead, MemWrite, createdump, WriteDataPC, WriteDataMem;
  logic [AW-1:0] ALUData;
  logic [DW-1:0] wdata, PCData, out, m_din, m_dout;
  logic          MemStall, MemErr, m_rd, m_wr, m_createdump, m_stall, m_done, m_err;
  logic [AW-1:0] m_addr;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int vectors = 0;
  int errors  = 0;
  int n_rd = 0, n_wr = 0, n_cd = 0;

  always #5 clk = ~clk;

  mem_stage_sb dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .createdump(createdump),
    .WriteDataPC(WriteDataPC), .WriteDataMem(WriteDataMem), .ALUData(ALUData), .wdata(wdata),
    .PCData(PCData), .out(out), .MemStall(MemStall), .MemErr(MemErr), .m_addr(m_addr),
    .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr), .m_createdump(m_createdump), .m_dout(m_dout),
    .m_stall(m_stall), .m_done(m_done), .m_err(m_err)
  );

  always @(negedge clk) begin
    if (m_rd) n_rd++;
    if (m_wr) n_wr++;
    if (m_createdump) n_cd++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    MemRead = 0; MemWrite = 0; createdump = 0; WriteDataPC = 0; WriteDataMem = 0;
    ALUData = '0; wdata = '0; PCData = '0; m_dout = '0;
    m_stall = 0; m_done = 0; m_err = 0;
  endtask

  task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemRead = 0; MemWrite = 1; ALUData = a; wdata = d;
    exp_q.push_back(wr_t'{addr: a, data: d});
  endtask

  // Memory model for drains: answer each m_wr with m_done one cycle later.
  task automatic service_writes(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      while (!m_wr && t < 20) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (!m_wr) begin
        errors++;
        $display("FAIL drain_wait: no m_wr within 20 cycles (write %0d)", i);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_extra: m_wr %h/%h with nothing expected", m_addr, m_din);
      end else begin
        e = exp_q.pop_front();
        if (m_addr !== e.addr || m_din !== e.data) begin
          errors++;
          $display("FAIL drain_order: got %h/%h want %h/%h", m_addr, m_din, e.addr, e.data);
        end
      end
      tick; m_done = 1;
      tick; m_done = 0;
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1; MemRead = 1; ALUData = 16'h0100; createdump = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({MemStall, m_rd, m_wr, m_createdump} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 0000", {MemStall, m_rd, m_wr, m_createdump});
      end
      tick;
    end
    rst = 0; idle_inputs; ALUData = 16'h1357;
    @(negedge clk);
    vectors++;
    if (MemErr !== 1'b0) begin errors++; $display("FAIL reset_memerr: got %b want 0", MemErr); end
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", MemStall); end
    vectors++;
    if (out !== 16'h1357) begin errors++; $display("FAIL out_alu: got %h want 1357", out); end
    tick;
    PCData = 16'hCAFE; WriteDataPC = 1; WriteDataMem = 1;
    @(negedge clk);
    vectors++;
    if (out !== 16'hCAFE) begin errors++; $display("FAIL out_pc: got %h want cafe", out); end
    tick; idle_inputs;
  endtask

  task automatic test_store_forward;
    int rd0;
    m_stall = 1;
    drive_store(16'h0040, 16'hBEEF);
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL fwd_store_stall: got %b want 0", MemStall); end
    tick;
    rd0 = n_rd;
    MemWrite = 0; MemRead = 1; WriteDataMem = 1; ALUData = 16'h0040;
    @(negedge clk);
    vectors++;
    if (out !== 16'hBEEF) begin errors++; $display("FAIL fwd_data: got %h want beef", out); end
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b want 0", MemStall); end
    tick;
    MemRead = 0; WriteDataMem = 0;
    vectors++;
    if (n_rd !== rd0) begin errors++; $display("FAIL fwd_no_rd: got %0d m_rd want 0", n_rd - rd0); end
    m_stall = 0;
    service_writes(1);
  endtask

  task automatic test_full_buffer;
    wr_t e;
    m_stall = 1;
    for (int i = 0; i < 4; i++) begin
      drive_store(16'h0010 + 16'(i), 16'h00A0 + 16'(i));
      @(negedge clk);
      vectors++;
      if (MemStall !== 1'b0) begin errors++; $display("FAIL full_store%0d_stall: got %b want 0", i, MemStall); end
      tick;
    end
    ALUData = 16'h0020; wdata = 16'h00C5;
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b1) begin errors++; $display("FAIL full_5th_stall: got %b want 1", MemStall); end
    tick;
    m_stall = 0;
    @(negedge clk);
    vectors++;
    e = exp_q.pop_front();
    if (m_wr !== 1'b1 || m_addr !== e.addr || m_din !== e.data) begin
      errors++;
      $display("FAIL full_head_wr: got wr=%b %h/%h want wr=1 %h/%h", m_wr, m_addr, m_din, e.addr, e.data);
    end
    vectors++;
    if (MemStall !== 1'b1) begin errors++; $display("FAIL full_hold_stall: got %b want 1", MemStall); end
    tick;
    m_stall = 1; m_done = 1;
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL full_done_enq: got stall %b want 0", MemStall); end
    exp_q.push_back(wr_t'{addr: 16'h0020, data: 16'h00C5});
    tick;
    MemWrite = 0; m_done = 0; m_stall = 0;
    service_writes(4);
  endtask

  task automatic test_load_miss;
    int rd0;
    rd0 = n_rd;
    MemRead = 1; WriteDataMem = 1; ALUData = 16'h0100; m_stall = 0;
    @(negedge clk);
    vectors++;
    if (m_rd !== 1'b1 || m_addr !== 16'h0100) begin
      errors++;
      $display("FAIL miss_req: got rd=%b addr=%h want rd=1 addr=0100", m_rd, m_addr);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (MemStall !== 1'b1) begin errors++; $display("FAIL miss_stall_c%0d: got %b want 1", c, MemStall); end
      tick;
      @(negedge clk);
    end
    m_done = 1; m_dout = 16'h1234;
    #1;
    vectors++;
    if (out !== 16'h1234) begin errors++; $display("FAIL miss_data: got %h want 1234", out); end
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL miss_release: got %b want 0", MemStall); end
    tick;
    MemRead = 0; WriteDataMem = 0; m_done = 0; m_dout = '0;
    tick; tick;
    vectors++;
    if (n_rd - rd0 !== 1) begin errors++; $display("FAIL miss_rd_count: got %0d want 1", n_rd - rd0); end
  endtask

  task automatic test_drain_order;
    logic [AW-1:0] a [3];
    a[0] = 16'h0A00; a[1] = 16'h0B00; a[2] = 16'h0A00;
    m_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_store(a[i], 16'(i + 1));
      @(negedge clk);
      vectors++;
      if (MemStall !== 1'b0) begin errors++; $display("FAIL order_store%0d_stall: got %b want 0", i, MemStall); end
      tick;
    end
    MemWrite = 0; MemRead = 1; WriteDataMem = 1; ALUData = 16'h0A00;
    @(negedge clk);
    vectors++;
    if (out !== 16'h0003 || MemStall !== 1'b0) begin
      errors++;
      $display("FAIL order_youngest: got out=%h stall=%b want 0003/0", out, MemStall);
    end
    tick;
    idle_inputs;
    service_writes(3);
  endtask

  task automatic test_createdump;
    int cd0, wr0, t;
    m_stall = 1;
    drive_store(16'h0030, 16'h0011); tick;
    drive_store(16'h0031, 16'h0022); tick;
    MemWrite = 0; m_stall = 0; createdump = 1;
    cd0 = n_cd; wr0 = n_wr;
    service_writes(2);
    vectors++;
    if (n_cd !== cd0 || n_wr - wr0 !== 2) begin
      errors++;
      $display("FAIL dump_early: got cd=%0d wr=%0d want cd=0 wr=2", n_cd - cd0, n_wr - wr0);
    end
    t = 0;
    @(negedge clk);
    while (!m_createdump && t < 20) begin @(negedge clk); t++; end
    vectors++;
    if (m_createdump !== 1'b1 || MemStall !== 1'b1) begin
      errors++;
      $display("FAIL dump_issue: got cd=%b stall=%b want 1/1", m_createdump, MemStall);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b1) begin errors++; $display("FAIL dump_wait_stall: got %b want 1", MemStall); end
    tick;
    m_done = 1;
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b0) begin errors++; $display("FAIL dump_release: got %b want 0", MemStall); end
    tick;
    createdump = 0; m_done = 0;
    tick;
    vectors++;
    if (n_cd - cd0 !== 1) begin errors++; $display("FAIL dump_count: got %0d want 1", n_cd - cd0); end
  endtask

  task automatic test_illegal;
    m_stall = 1; MemRead = 1; MemWrite = 1; ALUData = 16'h0060; wdata = 16'h6666;
    tick;
    idle_inputs; m_stall = 1;
    @(negedge clk);
    vectors++;
    if (MemErr !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", MemErr); end
    tick;
    MemRead = 1; WriteDataMem = 1; ALUData = 16'h0060;
    @(negedge clk);
    vectors++;
    if (MemStall !== 1'b1) begin errors++; $display("FAIL illegal_no_enq: got stall %b want 1", MemStall); end
    tick;
    idle_inputs; rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    vectors++;
    if (MemErr !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", MemErr); end
    tick;
  endtask

  task automatic test_err_reset;
    int sum0, wr0;
    m_stall = 1;
    MemWrite = 1; ALUData = 16'h0050; wdata = 16'h0055;
    tick;
    MemWrite = 0; m_stall = 0;
    @(negedge clk);
    vectors++;
    if (m_wr !== 1'b1 || m_addr !== 16'h0050) begin
      errors++;
      $display("FAIL err_wr_issue: got wr=%b addr=%h want 1/0050", m_wr, m_addr);
    end
    tick;
    m_err = 1;
    tick;
    m_err = 0; MemRead = 1; ALUData = 16'h0200; createdump = 1;
    sum0 = n_rd + n_wr + n_cd;
    for (int c = 0; c < 5; c++) begin
      m_done = (c == 4);
      @(negedge clk);
      vectors++;
      if (MemErr !== 1'b1 || MemStall !== 1'b1) begin
        errors++;
        $display("FAIL err_hold_c%0d: got err=%b stall=%b want 1/1", c, MemErr, MemStall);
      end
      tick;
    end
    m_done = 0;
    vectors++;
    if (n_rd + n_wr + n_cd !== sum0) begin
      errors++;
      $display("FAIL err_no_req: got %0d requests want 0", n_rd + n_wr + n_cd - sum0);
    end
    rst = 1;
    @(negedge clk);
    vectors++;
    if ({MemStall, m_rd, m_wr, m_createdump} !== 4'b0000) begin
      errors++;
      $display("FAIL err_rst_outputs: got %b want 0000", {MemStall, m_rd, m_wr, m_createdump});
    end
    tick;
    rst = 0; idle_inputs; m_done = 1;
    tick;
    m_done = 0;
    @(negedge clk);
    vectors++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL post_rst_state: got %0d want %0d", dut.r_state, IDLE); end
    vectors++;
    if (dut.u_sb.r_count !== '0) begin errors++; $display("FAIL post_rst_count: got %0d want 0", dut.u_sb.r_count); end
    vectors++;
    if (MemErr !== 1'b0) begin errors++; $display("FAIL post_rst_memerr: got %b want 0", MemErr); end
    tick;
    wr0 = n_wr;
    tick; tick; tick;
    vectors++;
    if (n_wr !== wr0) begin errors++; $display("FAIL post_rst_no_wr: got %0d m_wr want 0", n_wr - wr0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_forward();
    test_full_buffer();
    test_load_miss();
    test_drain_order();
    test_createdump();
    test_illegal();
    test_err_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
